// File: rtl/mac_stop_pkg.sv
// Shared types and width helpers for the matrix-multiply sequencer.
package mac_stop_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StWrite,
        StDone,
        StAbort
    } mac_ctrl_state_t;

    // Accumulator width: full product plus headroom for K summed terms.
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned k);
        return 2 * w + $clog2(k);
    endfunction

    // Index width for a dimension of n entries, never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_stop_idx_gen.sv
// Nested i/j/k index counter: k innermost, then j, then i.
module mac_stop_idx_gen
    import mac_stop_pkg::*;
#(
    parameter int unsigned M    = 4,
    parameter int unsigned K    = 4,
    parameter int unsigned N    = 4,
    parameter int unsigned AW_I = addr_width(M),
    parameter int unsigned AW_K = addr_width(K),
    parameter int unsigned AW_J = addr_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            step_k,
    input  logic            step_elem,
    output logic [AW_I-1:0] idx_i,
    output logic [AW_J-1:0] idx_j,
    output logic [AW_K-1:0] idx_k,
    output logic            last_k,
    output logic            last_elem
);

    localparam logic [AW_I-1:0] ILast = AW_I'(M - 1);
    localparam logic [AW_J-1:0] JLast = AW_J'(N - 1);
    localparam logic [AW_K-1:0] KLast = AW_K'(K - 1);
    localparam logic [AW_I-1:0] IOne  = AW_I'(1);
    localparam logic [AW_J-1:0] JOne  = AW_J'(1);
    localparam logic [AW_K-1:0] KOne  = AW_K'(1);

    logic [AW_I-1:0] r_i;
    logic [AW_J-1:0] r_j;
    logic [AW_K-1:0] r_k;

    assign idx_i     = r_i;
    assign idx_j     = r_j;
    assign idx_k     = r_k;
    assign last_k    = (r_k == KLast);
    assign last_elem = (r_i == ILast) && (r_j == JLast);

    // Counter update: element step restarts k and advances j, carrying into i.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (clear) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (step_elem) begin
            r_k <= '0;
            if (r_j == JLast) begin
                r_j <= '0;
                r_i <= (r_i == ILast) ? '0 : r_i + IOne;
            end else begin
                r_j <= r_j + JOne;
            end
        end else if (step_k && !last_k) begin
            r_k <= r_k + KOne;
        end
    end

endmodule

// File: rtl/mac_stop_ctrl.sv
// Abortable C = A x B sequencer: one MAC per cycle, one write per C element.
module mac_stop_ctrl
    import mac_stop_pkg::*;
#(
    parameter int unsigned M                        = 4,
    parameter int unsigned K                        = 4,
    parameter int unsigned N                        = 4,
    parameter int unsigned DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int unsigned DATA_WIDTH_RESULT_MATRIX = acc_width(DATA_WIDTH_INIT_MATRIX, K),
    parameter int unsigned ADDR_WIDTH_A             = addr_width(M),
    parameter int unsigned ADDR_WIDTH_B             = addr_width(K),
    parameter int unsigned ADDR_WIDTH_C             = addr_width(N)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                stop,
    output logic                                busy,
    output logic                                done,
    output logic                                aborted,
    output logic [ADDR_WIDTH_A-1:0]             row_addr_a,
    output logic [ADDR_WIDTH_B-1:0]             col_addr_a,
    output logic [ADDR_WIDTH_B-1:0]             row_addr_b,
    output logic [ADDR_WIDTH_C-1:0]             col_addr_b,
    output logic [ADDR_WIDTH_A-1:0]             row_addr_c,
    output logic [ADDR_WIDTH_C-1:0]             col_addr_c,
    output logic                                matrix_a_re,
    output logic                                matrix_b_re,
    output logic                                matrix_c_we,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b
);

    localparam int unsigned PW = 2 * DATA_WIDTH_INIT_MATRIX;

    mac_ctrl_state_t r_state, w_state_nxt;

    logic [DATA_WIDTH_RESULT_MATRIX-1:0] r_acc;
    logic [PW-1:0]                       w_prod;
    logic [ADDR_WIDTH_A-1:0]             w_idx_i;
    logic [ADDR_WIDTH_C-1:0]             w_idx_j;
    logic [ADDR_WIDTH_B-1:0]             w_idx_k;
    logic w_last_k, w_last_elem;
    logic w_clear, w_step_k, w_step_elem, w_acc_add, w_acc_clr, w_addr_en;

    mac_stop_idx_gen #(
        .M    (M),
        .K    (K),
        .N    (N),
        .AW_I (ADDR_WIDTH_A),
        .AW_K (ADDR_WIDTH_B),
        .AW_J (ADDR_WIDTH_C)
    ) u_idx_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .step_k    (w_step_k),
        .step_elem (w_step_elem),
        .idx_i     (w_idx_i),
        .idx_j     (w_idx_j),
        .idx_k     (w_idx_k),
        .last_k    (w_last_k),
        .last_elem (w_last_elem)
    );

    // Read data is combinational, so the product is formed in the address cycle.
    assign w_prod = PW'(data_out_a) * PW'(data_out_b);

    // Addresses only leave zero while the controller is walking the matrices.
    assign row_addr_a = w_addr_en ? w_idx_i : '0;
    assign col_addr_a = w_addr_en ? w_idx_k : '0;
    assign row_addr_b = w_addr_en ? w_idx_k : '0;
    assign col_addr_b = w_addr_en ? w_idx_j : '0;
    assign row_addr_c = w_addr_en ? w_idx_i : '0;
    assign col_addr_c = w_addr_en ? w_idx_j : '0;
    assign data_in_c  = (r_state == StWrite) ? r_acc : '0;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator: cleared at run start and after each C write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_acc_clr) begin
            r_acc <= '0;
        end else if (w_acc_add) begin
            r_acc <= r_acc + DATA_WIDTH_RESULT_MATRIX'(w_prod);
        end
    end

    // Next-state, counter control and strobe decode; stop suppresses the pending write.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_step_k    = 1'b0;
        w_step_elem = 1'b0;
        w_acc_add   = 1'b0;
        w_acc_clr   = 1'b0;
        w_addr_en   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        aborted     = 1'b0;
        matrix_a_re = 1'b0;
        matrix_b_re = 1'b0;
        matrix_c_we = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start && !stop) begin
                    w_state_nxt = StMac;
                    w_clear     = 1'b1;
                    w_acc_clr   = 1'b1;
                end
            end
            StMac: begin
                busy        = 1'b1;
                w_addr_en   = 1'b1;
                matrix_a_re = 1'b1;
                matrix_b_re = 1'b1;
                if (stop) begin
                    w_state_nxt = StAbort;
                end else begin
                    w_acc_add = 1'b1;
                    if (w_last_k) begin
                        w_state_nxt = StWrite;
                    end else begin
                        w_step_k = 1'b1;
                    end
                end
            end
            StWrite: begin
                busy      = 1'b1;
                w_addr_en = 1'b1;
                if (stop) begin
                    w_state_nxt = StAbort;
                end else begin
                    matrix_c_we = 1'b1;
                    w_step_elem = 1'b1;
                    w_acc_clr   = 1'b1;
                    w_state_nxt = w_last_elem ? StDone : StMac;
                end
            end
            StDone: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = StIdle;
            end
            StAbort: begin
                busy        = 1'b1;
                aborted     = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

endmodule
